// File: rtl/key_pkg.sv
// key_pkg: shared state encoding, default timing constants and width helper for the key debouncer
package key_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FILTER0 = 2'd1;
    localparam logic [1:0] ST_DOWN    = 2'd2;
    localparam logic [1:0] ST_FILTER1 = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        FILTER0 = ST_FILTER0,
        DOWN    = ST_DOWN,
        FILTER1 = ST_FILTER1
    } key_state_e;

    // 20 ms debounce and 1 s long-press at 50 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_LONG_CYCLES     = 50_000_000;

    // Counter width able to hold values 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel: one key - pin synchroniser, debounce FSM, long-press counter and toggle bit
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic toggle_state
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int LW = cnt_width(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);
    // The counter parks one past LONG_LAST so the long pulse can only fire once per press
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
    localparam logic [1:0]    PIN_IDLE  = {2{ACTIVE_LOW}};

    logic [1:0]    sync_q, sync_d;
    key_state_e    state_q, state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [LW-1:0] long_cnt_q, long_cnt_d;
    logic          toggle_q, toggle_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          act;

    // Next-state logic: accept a level only after it has been stable for the full hold time
    always_comb begin
        sync_d     = {sync_q[0], key_in};
        act        = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        long_cnt_d = long_cnt_q;
        toggle_d   = toggle_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (act) begin
                    state_d   = FILTER0;
                    deb_cnt_d = '0;
                end
            end
            FILTER0: begin
                if (!act) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = DOWN;
                    press_d    = 1'b1;
                    toggle_d   = ~toggle_q;
                    long_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            DOWN: begin
                if (LONG_CYCLES > 0 && long_cnt_q != LONG_MAX) begin
                    long_cnt_d = long_cnt_q + LW'(1);
                    long_d     = long_cnt_q == LONG_LAST;
                end
                if (!act) begin
                    state_d   = FILTER1;
                    deb_cnt_d = '0;
                end
            end
            FILTER1: begin
                if (act) begin
                    state_d = DOWN;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
        endcase
        level_d = (state_d == DOWN) || (state_d == FILTER1);
    end

    // State, counters and registered outputs; reset parks the synchroniser at the released pin level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= PIN_IDLE;
            state_q    <= IDLE;
            deb_cnt_q  <= '0;
            long_cnt_q <= '0;
            toggle_q   <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            long_cnt_q <= long_cnt_d;
            toggle_q   <= toggle_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign toggle_state  = toggle_q;

endmodule

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: NUM_KEYS independent debounced key channels
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] toggle_state
);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .key_in       (key_in[k]),
            .key_level    (key_level[k]),
            .press_pulse  (press_pulse[k]),
            .release_pulse(release_pulse[k]),
            .long_pulse   (long_pulse[k]),
            .toggle_state (toggle_state[k])
        );
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: vector table, latency sequences and random pins against a run-length reference model
module tb_key_debounce_multi;

    localparam int NK = 2;
    localparam int DC = 4;
    localparam int LC = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_in = '1;
    logic [NK-1:0] key_level, press_pulse, release_pulse, long_pulse, toggle_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_debounce_multi #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DC),
        .LONG_CYCLES    (LC),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key_in),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .toggle_state (toggle_state)
    );

    // Reference model: a key flips its accepted level after DC+1 consecutive
    // disagreeing samples of the twice-delayed pin; held time counts clean pressed cycles.
    logic [NK-1:0] m_h0, m_h1, m_pressed, m_press, m_rel, m_long, m_tog;
    int m_run [NK];
    int m_held [NK];
    int n_press [NK];
    int n_rel [NK];
    int n_long [NK];

    task automatic check(input string name, input logic [NK-1:0] got, input logic [NK-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_h0 = '1; m_h1 = '1;
        m_pressed = '0; m_press = '0; m_rel = '0; m_long = '0; m_tog = '0;
        for (int k = 0; k < NK; k++) begin
            m_run[k] = 0;
            m_held[k] = 0;
        end
    endtask

    task automatic model_edge();
        logic act;
        for (int k = 0; k < NK; k++) begin
            act = !m_h1[k];
            m_press[k] = 1'b0; m_rel[k] = 1'b0; m_long[k] = 1'b0;
            if (m_pressed[k] && m_run[k] == 0 && m_held[k] < LC) begin
                m_held[k]++;
                m_long[k] = (m_held[k] == LC);
            end
            if (act != m_pressed[k]) begin
                m_run[k]++;
                if (m_run[k] == DC + 1) begin
                    m_pressed[k] = act;
                    m_run[k] = 0;
                    m_press[k] = act;
                    m_rel[k] = !act;
                    if (act) begin
                        m_tog[k] = ~m_tog[k];
                        m_held[k] = 0;
                    end
                end
            end else begin
                m_run[k] = 0;
            end
        end
        m_h1 = m_h0;
        m_h0 = key_in;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NK; k++) begin
            n_press[k] = 0; n_rel[k] = 0; n_long[k] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge(); else model_reset();
        @(negedge clk);
        check("model key_level", key_level, m_pressed);
        check("model press_pulse", press_pulse, m_press);
        check("model release_pulse", release_pulse, m_rel);
        check("model long_pulse", long_pulse, m_long);
        check("model toggle_state", toggle_state, m_tog);
        for (int k = 0; k < NK; k++) begin
            n_press[k] += int'(press_pulse[k]);
            n_rel[k]   += int'(release_pulse[k]);
            n_long[k]  += int'(long_pulse[k]);
        end
    endtask

    // kind: 0 press, 1 release, 2 long; n = ticks until seen, -1 if the budget ran out
    task automatic wait_pulse(input int ch, input int kind, input int limit, output int n);
        logic [NK-1:0] v;
        n = -1;
        for (int t = 1; t <= limit; t++) begin
            tick();
            v = (kind == 0) ? press_pulse : (kind == 1) ? release_pulse : long_pulse;
            if (v[ch]) begin
                n = t;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " key_level"}, key_level, '0);
        check({tag, " press_pulse"}, press_pulse, '0);
        check({tag, " release_pulse"}, release_pulse, '0);
        check({tag, " long_pulse"}, long_pulse, '0);
        check({tag, " toggle_state"}, toggle_state, '0);
    endtask

    typedef struct {
        logic [NK-1:0] pin;
        int            cyc;
        logic [NK-1:0] e_press;
        logic [NK-1:0] e_rel;
        logic [NK-1:0] e_long;
        logic [NK-1:0] e_level;
        logic [NK-1:0] e_tog;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog at %0t: simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rem [NK];
        // pin, cycles, press, release, long, level at end, toggle at end
        vecs[0]  = '{2'b10, 12, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
        vecs[1]  = '{2'b11, 12, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
        vecs[2]  = '{2'b10,  3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        vecs[3]  = '{2'b11, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        vecs[4]  = '{2'b10,  4, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        vecs[5]  = '{2'b11, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        vecs[6]  = '{2'b10,  5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        vecs[7]  = '{2'b11, 12, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[8]  = '{2'b00, 10, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11};
        vecs[9]  = '{2'b11, 10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11};
        vecs[10] = '{2'b00, 10, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00};
        vecs[11] = '{2'b11, 10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
        vecs[12] = '{2'b01, 30, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10};
        vecs[13] = '{2'b11, 10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10};

        model_reset();
        clear_counts();
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 14; i++) begin
            key_in = vecs[i].pin;
            clear_counts();
            repeat (vecs[i].cyc) tick();
            for (int k = 0; k < NK; k++) begin
                check_int($sformatf("vec%0d press count ch%0d", i, k), n_press[k], int'(vecs[i].e_press[k]));
                check_int($sformatf("vec%0d release count ch%0d", i, k), n_rel[k], int'(vecs[i].e_rel[k]));
                check_int($sformatf("vec%0d long count ch%0d", i, k), n_long[k], int'(vecs[i].e_long[k]));
            end
            check($sformatf("vec%0d key_level", i), key_level, vecs[i].e_level);
            check($sformatf("vec%0d toggle_state", i), toggle_state, vecs[i].e_tog);
        end

        // Press latency, single long pulse 20 cycles after press, release latency
        key_in = 2'b10;
        wait_pulse(0, 0, 30, n);
        check_int("press latency", n, 7);
        check("press only ch0", press_pulse, 2'b01);
        check("level at press", key_level, 2'b01);
        wait_pulse(0, 2, 40, n);
        check_int("long latency", n, 20);
        clear_counts();
        repeat (15) tick();
        check_int("no second long", n_long[0], 0);
        key_in = 2'b11;
        wait_pulse(0, 1, 30, n);
        check_int("release latency", n, 7);
        check("level after release", key_level, 2'b00);
        repeat (3) tick();

        // Release bounce: pin high for 2 cycles while pressed is ignored
        key_in = 2'b10;
        wait_pulse(0, 0, 30, n);
        check_int("bounce press latency", n, 7);
        key_in = 2'b11;
        clear_counts();
        tick();
        tick();
        key_in = 2'b10;
        repeat (15) tick();
        check_int("bounce release count", n_rel[0], 0);
        check_int("bounce press count", n_press[0], 0);
        check("bounce level held", key_level, 2'b01);
        key_in = 2'b11;
        repeat (12) tick();

        // Reset while held: outputs clear at once, key re-accepted after full debounce
        key_in = 2'b10;
        wait_pulse(0, 0, 30, n);
        check_int("pre-reset press latency", n, 7);
        repeat (3) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("async reset");
        clear_counts();
        repeat (3) tick();
        check_int("no release on reset", n_rel[0], 0);
        rst_n = 1'b1;
        wait_pulse(0, 0, 30, n);
        check_int("press after reset", n, 7);
        check("toggle after reset press", toggle_state, 2'b01);
        key_in = 2'b11;
        repeat (12) tick();

        // Random pins with runs both shorter and longer than the debounce window
        for (int k = 0; k < NK; k++) rem[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (rem[k] == 0) begin
                    key_in[k] = ~key_in[k];
                    rem[k] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : int'($urandom_range(5, 40));
                end
                rem[k]--;
            end
            if (c == 1500) begin
                rst_n = 1'b0;
                model_reset();
            end
            if (c == 1503) rst_n = 1'b1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
